// File: rtl/ffnet_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : ffnet_pkg                                                         |
// | Purpose : Shared constants and types for the LUT-net layer sequencer.      |
// |           - DIV_W_DEFAULT : default width of the step-rate divider config  |
// |           - pipe_mode_e   : single-sample vs. pipelined operation           |
// |           - PERF_W        : width of the optional performance counters     |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package ffnet_pkg;

  localparam int DIV_W_DEFAULT = 8;
  localparam int PERF_W        = 16;

  typedef enum logic {
    MODE_SINGLE    = 1'b0,
    MODE_PIPELINED = 1'b1
  } pipe_mode_e;

  // Maps the integer PIPELINED parameter onto the mode encoding.
  function automatic pipe_mode_e mode_of(input int pipelined);
    return (pipelined != 0) ? MODE_PIPELINED : MODE_SINGLE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ffnet_step_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ffnet_step_div                                                    |
// | Purpose : Layer step-rate divider. Emits a one-clock tick every             |
// |           div_cfg+1 clocks while the sequencer is active and not stalled.  |
// | Ports   : clock, reset   - clock / async active-high reset                 |
// |           active         - a sample is injected or in flight               |
// |           stall          - last stage holds a result that cannot leave     |
// |           div_cfg        - clocks between steps minus 1                    |
// |           tick           - advance the token chain this cycle              |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ffnet_step_div
  import ffnet_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             active,
  input  logic             stall,
  input  logic [DIV_W-1:0] div_cfg,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = 1;

  logic [DIV_W-1:0] count;

  // Idle forces the counter to zero so the first step after an accept
  // happens immediately. div_cfg is only looked at on reload, so a change
  // mid-run takes effect after the next step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!active) begin
      count <= '0;
    end else if (!stall) begin
      if (count == '0) begin
        count <= div_cfg;
      end else begin
        count <= count - ONE;
      end
    end
  end

  assign tick = active & ~stall & (count == '0);

endmodule
`default_nettype wire

// File: rtl/ffnet_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ffnet_seq                                                         |
// | Purpose : Layer sequencer for a generated LUT net. Accepts input vectors   |
// |           on a valid/ready handshake, walks a one-hot token through        |
// |           N_LAYERS stages at a programmable rate, strobes each layer's     |
// |           capture enable and returns results on a valid/ready output.      |
// | Ports   : clock, reset          - clock / async active-high reset          |
// |           div_cfg               - clocks between layer steps minus 1       |
// |           in_valid/in_ready/in_data   - input handshake                    |
// |           net_in                - registered vector feeding layer 0        |
// |           layer_en              - per-layer one-clock capture strobes      |
// |           net_out               - last-layer register output of the net    |
// |           out_valid/out_ready/out_data - result handshake                  |
// |           busy                  - sample injected or in flight             |
// | Options : FFNET_SEQ_PERF_EN adds stall_cnt (saturating stall cycles) and   |
// |           result_cnt (wrapping captured results).                          |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ffnet_seq
  import ffnet_pkg::*;
#(
  parameter int N_INPUTS  = 4,
  parameter int N_OUTPUTS = 1,
  parameter int N_LAYERS  = 3,
  parameter int DIV_W     = DIV_W_DEFAULT,
  parameter int PIPELINED = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     div_cfg,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_INPUTS-1:0]  in_data,
  output logic [N_INPUTS-1:0]  net_in,
  output logic [N_LAYERS-1:0]  layer_en,
  input  logic [N_OUTPUTS-1:0] net_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_OUTPUTS-1:0] out_data,
  output logic                 busy
`ifdef FFNET_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0]    stall_cnt,
  output logic [PERF_W-1:0]    result_cnt
`endif
);

  localparam pipe_mode_e MODE = mode_of(PIPELINED);
  localparam int         LAST = N_LAYERS - 1;

  logic                inj;      // net_in holds a sample not yet taken by layer 0
  logic [N_LAYERS-1:0] tok;      // tok[k]: layer k register holds valid data
  logic [N_LAYERS-1:0] src;      // what each stage would receive on a step
  logic                accept;
  logic                capture;
  logic                stall;
  logic                tick;
  logic                active;

  generate
    if (N_LAYERS == 1) begin : g_src_single
      assign src = inj;
    end else begin : g_src_chain
      assign src = {tok[N_LAYERS-2:0], inj};
    end
  endgenerate

  assign active   = inj | (|tok);
  assign busy     = active;
  assign in_ready = ~inj & ((MODE == MODE_PIPELINED) | (tok == '0));
  assign accept   = in_valid & in_ready;

  // A result leaves the last stage whenever the output register is free
  // or being drained this cycle; otherwise the whole chain must freeze.
  assign capture  = tok[LAST] & (~out_valid | out_ready);
  assign stall    = tok[LAST] & ~capture;

  // Strobes come straight from the token registers, so reset removes them
  // in the same instant it clears the tokens.
  assign layer_en = tick ? src : '0;

  ffnet_step_div #(
    .DIV_W (DIV_W)
  ) u_step_div (
    .clock   (clock),
    .reset   (reset),
    .active  (active),
    .stall   (stall),
    .div_cfg (div_cfg),
    .tick    (tick)
  );

  // Token chain and input register. A step shifts every stage at once; a
  // capture without a step only empties the last stage. Accept cannot
  // coincide with a step that consumes inj because in_ready needs ~inj.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inj    <= 1'b0;
      tok    <= '0;
      net_in <= '0;
    end else begin
      if (tick) begin
        inj <= 1'b0;
        tok <= src;
      end else if (capture) begin
        tok[LAST] <= 1'b0;
      end
      if (accept) begin
        net_in <= in_data;
        inj    <= 1'b1;
      end
    end
  end

  // Output register: held stable while out_valid & ~out_ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (capture) begin
      out_data  <= net_out;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FFNET_SEQ_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = 1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      result_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + PERF_ONE;
      end
      if (capture) begin
        result_cnt <= result_cnt + PERF_ONE;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ffnet_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ffnet_seq                                                      |
// | Purpose : Self-checking bench for ffnet_seq. One single-sample and one     |
// |           pipelined instance, each driving a small 3-layer stand-in net.   |
// |           Results are checked against a queue of accepted inputs mapped    |
// |           through the net's end-to-end function.                           |
// | Options : FFNET_SEQ_PERF_EN enables the performance counter checks.        |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_ffnet_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] div_cfg;

  logic       np_in_valid, np_in_ready, np_out_valid, np_out_ready, np_busy;
  logic [3:0] np_in_data, np_net_in, np_net_out, np_out_data;
  logic [2:0] np_layer_en;
  logic       pp_in_valid, pp_in_ready, pp_out_valid, pp_out_ready, pp_busy;
  logic [3:0] pp_in_data, pp_net_in, pp_net_out, pp_out_data;
  logic [2:0] pp_layer_en;
`ifdef FFNET_SEQ_PERF_EN
  logic [15:0] np_stall_cnt, np_result_cnt, pp_stall_cnt, pp_result_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ffnet_seq #(.N_INPUTS(4), .N_OUTPUTS(4), .N_LAYERS(3), .DIV_W(8), .PIPELINED(0)) u_np (
    .clock(clock), .reset(reset), .div_cfg(div_cfg),
    .in_valid(np_in_valid), .in_ready(np_in_ready), .in_data(np_in_data),
    .net_in(np_net_in), .layer_en(np_layer_en), .net_out(np_net_out),
    .out_valid(np_out_valid), .out_ready(np_out_ready), .out_data(np_out_data),
    .busy(np_busy)
`ifdef FFNET_SEQ_PERF_EN
    , .stall_cnt(np_stall_cnt), .result_cnt(np_result_cnt)
`endif
  );

  ffnet_seq #(.N_INPUTS(4), .N_OUTPUTS(4), .N_LAYERS(3), .DIV_W(8), .PIPELINED(1)) u_pp (
    .clock(clock), .reset(reset), .div_cfg(div_cfg),
    .in_valid(pp_in_valid), .in_ready(pp_in_ready), .in_data(pp_in_data),
    .net_in(pp_net_in), .layer_en(pp_layer_en), .net_out(pp_net_out),
    .out_valid(pp_out_valid), .out_ready(pp_out_ready), .out_data(pp_out_data),
    .busy(pp_busy)
`ifdef FFNET_SEQ_PERF_EN
    , .stall_cnt(pp_stall_cnt), .result_cnt(pp_result_cnt)
`endif
  );

  // Stand-in LUT nets: three registered layers each.
  logic [3:0] np_l0, np_l1, np_l2, pp_l0, pp_l1, pp_l2;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      np_l0 <= '0; np_l1 <= '0; np_l2 <= '0;
      pp_l0 <= '0; pp_l1 <= '0; pp_l2 <= '0;
    end else begin
      if (np_layer_en[0]) np_l0 <= np_net_in ^ 4'h6;
      if (np_layer_en[1]) np_l1 <= {np_l0[2:0], np_l0[3]};
      if (np_layer_en[2]) np_l2 <= np_l1 + 4'h5;
      if (pp_layer_en[0]) pp_l0 <= pp_net_in ^ 4'h6;
      if (pp_layer_en[1]) pp_l1 <= {pp_l0[2:0], pp_l0[3]};
      if (pp_layer_en[2]) pp_l2 <= pp_l1 + 4'h5;
    end
  end
  assign np_net_out = np_l2;
  assign pp_net_out = pp_l2;

  // End-to-end function of the stand-in net.
  function automatic logic [3:0] model(input logic [3:0] x);
    logic [3:0] y;
    y = x ^ 4'h6;
    y = {y[2:0], y[3]};
    return y + 4'h5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: inputs accepted, in order; results must come out in order.
  logic [3:0] np_q[$];
  logic [3:0] pp_q[$];
  int         np_pops = 0, pp_pops = 0;
  logic       np_hold = 1'b0, pp_hold = 1'b0;
  logic [3:0] np_hold_data, pp_hold_data;

  always @(negedge clock) begin
    if (reset) begin
      np_q.delete(); pp_q.delete();
      np_hold = 1'b0; pp_hold = 1'b0;
    end else begin
      if (np_hold) begin
        chk("np_hold_valid", 32'(np_out_valid), 32'd1);
        chk("np_hold_data", 32'(np_out_data), 32'(np_hold_data));
      end
      if (pp_hold) begin
        chk("pp_hold_valid", 32'(pp_out_valid), 32'd1);
        chk("pp_hold_data", 32'(pp_out_data), 32'(pp_hold_data));
      end
      chk("np_ready_iff_idle", 32'(np_in_ready), 32'(!np_busy));
      chk("np_single_strobe", 32'($onehot0(np_layer_en)), 32'd1);
      if (np_out_valid && np_out_ready) begin
        chk("np_result_pending", 32'(np_q.size() != 0), 32'd1);
        if (np_q.size() != 0) begin
          chk("np_result", 32'(np_out_data), 32'(model(np_q.pop_front())));
          np_pops++;
        end
      end
      if (pp_out_valid && pp_out_ready) begin
        chk("pp_result_pending", 32'(pp_q.size() != 0), 32'd1);
        if (pp_q.size() != 0) begin
          chk("pp_result", 32'(pp_out_data), 32'(model(pp_q.pop_front())));
          pp_pops++;
        end
      end
      if (np_in_valid && np_in_ready) np_q.push_back(np_in_data);
      if (pp_in_valid && pp_in_ready) pp_q.push_back(pp_in_data);
      np_hold = np_out_valid && !np_out_ready;
      np_hold_data = np_out_data;
      pp_hold = pp_out_valid && !pp_out_ready;
      pp_hold_data = pp_out_data;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    np_in_valid = 1'b0; pp_in_valid = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    settle();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    np_in_valid = 1'b0; pp_in_valid = 1'b0;
    np_out_ready = 1'b1; pp_out_ready = 1'b1;
    while ((np_busy || np_out_valid || pp_busy || pp_out_valid) && n < 200) begin
      cyc(); settle(); n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  initial begin
    int   t0, t1, t2, lo, n, acc, base;
    logic hs;
    logic [3:0] pd[4];
    pd[0] = 4'h1; pd[1] = 4'h7; pd[2] = 4'hB; pd[3] = 4'h4;

    reset = 1'b1; div_cfg = '0;
    np_in_valid = 1'b0; np_in_data = '0; np_out_ready = 1'b1;
    pp_in_valid = 1'b0; pp_in_data = '0; pp_out_ready = 1'b1;
    cyc(); cyc(); settle();
    // {in_ready, layer_en, net_in, out_valid, out_data, busy}
    chk("np_reset_state", 32'({np_in_ready, np_layer_en, np_net_in, np_out_valid, np_out_data, np_busy}),
        32'({1'b1, 3'b000, 4'h0, 1'b0, 4'h0, 1'b0}));
    chk("pp_reset_state", 32'({pp_in_ready, pp_layer_en, pp_net_in, pp_out_valid, pp_out_data, pp_busy}),
        32'({1'b1, 3'b000, 4'h0, 1'b0, 4'h0, 1'b0}));
    cyc(); reset = 1'b0; settle();

    // Latency and strobe order, div_cfg=0, no back-pressure.
    np_in_valid = 1'b1; np_in_data = 4'hA; settle();
    chk("t1_in_ready_c0", 32'(np_in_ready), 32'd1);
    cyc(); np_in_valid = 1'b0; settle();
    chk("t1_en_c1", 32'(np_layer_en), 32'b001);
    chk("t1_net_in", 32'(np_net_in), 32'hA);
    chk("t1_in_ready_c1", 32'(np_in_ready), 32'd0);
    cyc(); settle(); chk("t1_en_c2", 32'(np_layer_en), 32'b010);
    cyc(); settle(); chk("t1_en_c3", 32'(np_layer_en), 32'b100);
    cyc(); settle(); chk("t1_out_valid_c4", 32'(np_out_valid), 32'd0);
    chk("t1_en_c4", 32'(np_layer_en), 32'b000);
    cyc(); settle(); chk("t1_out_valid_c5", 32'(np_out_valid), 32'd1);
    chk("t1_out_data", 32'(np_out_data), 32'(model(4'hA)));
    chk("t1_in_ready_c5", 32'(np_in_ready), 32'd1);
    cyc(); settle(); chk("t1_out_valid_c6", 32'(np_out_valid), 32'd0);
    chk("t1_busy_c6", 32'(np_busy), 32'd0);

    // Step spacing; div_cfg changed after the first step takes effect on
    // the following reload only.
    div_cfg = 8'd3; np_in_valid = 1'b1; np_in_data = 4'h3;
    cyc(); np_in_valid = 1'b0;
    t0 = -1; t1 = -1; t2 = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 2) div_cfg = 8'd1;
      settle();
      if (np_layer_en == 3'b001) t0 = k;
      if (np_layer_en == 3'b010) t1 = k;
      if (np_layer_en == 3'b100) t2 = k;
      cyc();
    end
    settle();
    chk("t2_first_step", 32'(t0), 32'd1);
    chk("t2_old_spacing", 32'(t1 - t0), 32'd4);
    chk("t2_new_spacing", 32'(t2 - t1), 32'd2);
    div_cfg = '0;

    // Single-sample hold-off with the consumer stalled.
    base = np_pops;
    np_out_ready = 1'b0; np_in_valid = 1'b1; np_in_data = 4'h5; settle();
    chk("t3_in_ready_c0", 32'(np_in_ready), 32'd1);
    cyc(); np_in_data = 4'hC; settle();
    lo = 0;
    while (!np_in_ready && lo < 12) begin
      lo++; cyc(); settle();
    end
    chk("t3_ready_low_cycles", 32'(lo), 32'd4);
    chk("t3_out_valid_c5", 32'(np_out_valid), 32'd1);
    cyc(); np_in_valid = 1'b0; settle();
    chk("t3_second_accepted", 32'(np_in_ready), 32'd0);
    for (int k = 0; k < 8; k++) begin cyc(); settle(); end
    chk("t3_held_data", 32'(np_out_data), 32'(model(4'h5)));
    chk("t3_stalled_busy", 32'(np_busy), 32'd1);
    drain("t3_drain_timeout");
    chk("t3_results_out", 32'(np_pops - base), 32'd2);

    // Reset mid-operation: while tok=010.
    np_in_valid = 1'b1; np_in_data = 4'h9;
    cyc(); np_in_valid = 1'b0; cyc(); cyc();
    reset = 1'b1; settle();
    chk("t4_reset_now", 32'({np_in_ready, np_layer_en, np_net_in, np_out_valid, np_out_data, np_busy}),
        32'({1'b1, 3'b000, 4'h0, 1'b0, 4'h0, 1'b0}));
    cyc(); settle();
    chk("t4_no_strobe", 32'(np_layer_en), 32'd0);
    reset = 1'b0;
    np_in_valid = 1'b1; np_in_data = 4'h7;
    cyc(); np_in_valid = 1'b0; settle();
    n = 1;
    while (!np_out_valid && n < 20) begin cyc(); settle(); n++; end
    chk("t4_latency_after_reset", 32'(n), 32'd5);
    chk("t4_out_data", 32'(np_out_data), 32'(model(4'h7)));
    drain("t4_drain_timeout");

    // Pipelined mode: four inputs with the consumer stalled, then release.
    do_reset();
    base = pp_pops;
    acc = 0;
    pp_in_valid = 1'b1; pp_in_data = pd[0];
    for (int c = 0; c < 40; c++) begin
      pp_out_ready = (c >= 16);
      settle();
      if (c == 10) begin
        chk("t5_frozen_en", 32'(pp_layer_en), 32'd0);
        chk("t5_frozen_in_ready", 32'(pp_in_ready), 32'd0);
        chk("t5_held_valid", 32'(pp_out_valid), 32'd1);
        chk("t5_held_data", 32'(pp_out_data), 32'(model(pd[0])));
        chk("t5_busy", 32'(pp_busy), 32'd1);
      end
`ifdef FFNET_SEQ_PERF_EN
      if (c == 16) chk("t5_stall_cnt", 32'(pp_stall_cnt), 32'd10);
`endif
      hs = pp_in_valid && pp_in_ready;
      cyc();
      if (hs) begin
        acc++;
        if (acc == 4) pp_in_valid = 1'b0;
        else pp_in_data = pd[acc];
      end
    end
    settle();
    chk("t5_accepts", 32'(acc), 32'd4);
    chk("t5_results_out", 32'(pp_pops - base), 32'd4);
    chk("t5_idle", 32'(pp_busy), 32'd0);
`ifdef FFNET_SEQ_PERF_EN
    chk("t5_stall_cnt_final", 32'(pp_stall_cnt), 32'd10);
    chk("t5_result_cnt", 32'(pp_result_cnt), 32'd4);
`endif

    // Randomized traffic on both instances.
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 0) div_cfg = 8'($urandom_range(0, 3));
      np_in_valid  = 1'($urandom_range(0, 1));
      np_in_data   = 4'($urandom);
      np_out_ready = ($urandom_range(0, 9) < 6);
      pp_in_valid  = 1'($urandom_range(0, 1));
      pp_in_data   = 4'($urandom);
      pp_out_ready = ($urandom_range(0, 9) < 6);
      cyc();
    end
    settle();
    drain("t6_drain_timeout");
    chk("t6_np_queue_empty", 32'(np_q.size()), 32'd0);
    chk("t6_pp_queue_empty", 32'(pp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ffnet_seq.md
Name: ffnet_seq

Overview:
- Parametrised successor to the one-shot LUT-net layer sequencer.
- Accepts input vectors over a valid/ready handshake and steps a one-hot token through N_LAYERS layer stages at a runtime-programmable rate.
- Drives per-layer capture enables into the generated LUT layers and returns net results over a valid/ready output with back-pressure.
- Optional pipelined mode keeps several samples in flight, one per layer.

Parameters:
- N_INPUTS, 4, width of input vector / net_in.
- N_OUTPUTS, 1, width of net_out / out_data.
- N_LAYERS, 3, number of layer stages (>=1).
- DIV_W, 8, width of div_cfg.
- PIPELINED, 0, 0 = one sample in flight; 1 = up to one sample per layer.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- div_cfg  in  DIV_W  clocks between layer steps minus 1 (0 = step every clock).
- in_valid  in  1  input vector offered.
- in_ready  out  1  block can accept an input.
- in_data  in  N_INPUTS  input vector.
- net_in  out  N_INPUTS  registered input vector to layer 0.
- layer_en  out  N_LAYERS  one-clock capture strobe per layer register.
- net_out  in  N_OUTPUTS  last-layer register output from the generated net.
- out_valid  out  1  out_data holds an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  N_OUTPUTS  captured result.
- busy  out  1  inj or any token set.

Behaviour:
- Reset values: in_ready=1, layer_en=0, net_in=0, out_valid=0, out_data=0, busy=0; inj=0, tok=0, step counter=0.
- Accept: in_valid&in_ready → net_in<=in_data, inj<=1.
- in_ready = ~inj & (PIPELINED | tok==0).
- Step counter:
  - Held at 0 while idle (inj==0, tok==0).
  - When active: tick when counter==0 and not stalled, then reload div_cfg. Otherwise decrement.
  - div_cfg is sampled only at reload.
- Sources: src[0]=inj; src[k]=tok[k-1] for k>=1.
- On tick:
  - layer_en[k]=src[k] (combinational from registers, asserted only in the tick cycle).
  - tok[k]<=src[k].
  - inj<=0.
- tok[k]=1 means layer k's register holds valid data.
- Result capture: any cycle with tok[N_LAYERS-1]=1 and (out_valid==0 | out_ready):
  - out_data<=net_out, out_valid<=1.
  - tok[N_LAYERS-1] cleared, unless a same-cycle tick reloads it from tok[N_LAYERS-2].
- Output handshake: out_ready & out_valid with no capture → out_valid<=0. out_data is stable while out_valid & ~out_ready.
- Stall: tok[N_LAYERS-1]=1 and no capture this cycle.
  - No tick; counter holds; all tokens freeze.
  - No result is ever overwritten or dropped.
- Simultaneous events:
  - Accept in the same cycle as a tick consuming inj is impossible, because in_ready requires ~inj.
  - Capture and a new tick in the same cycle are both honoured.
- Latency (div_cfg=0, no back-pressure): accept handshake at cycle 0 → out_valid at cycle N_LAYERS+2.
- Non-pipelined throughput: next accept the cycle after the result is captured.
- N_LAYERS=1: tok[0] is the last stage; all rules hold.
- Reset mid-operation: all tokens and in-flight results are discarded immediately. No layer_en pulse occurs after reset asserts.

Optional Feature:
- Macro FFNET_SEQ_PERF_EN adds two outputs:
  - stall_cnt[15:0]: saturating count of stall cycles.
  - result_cnt[15:0]: wrapping count of captured results.
- Both are reset to 0.
- Without the macro these ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package ffnet_pkg: DIV_W default, PIPELINED mode encodings, perf counter width constant.
- One sub-module, ffnet_step_div: counter reload, hold and stall gating; emits tick.
- Token chain, handshakes and output register stay in ffnet_seq.

Test Plan:
- N_LAYERS=3, div_cfg=0, in_data=4'hA, net_out model = registered XOR of layers, out_ready=1 → layer_en 001,010,100 on consecutive cycles; out_valid at cycle 5; out_data matches model.
- div_cfg=3 → layer_en pulses exactly 4 clocks apart; change div_cfg mid-run → new spacing only after the next reload.
- PIPELINED=1, three back-to-back inputs, out_ready=0 for 10 cycles → pipe freezes with tok=111, one held result; after out_ready=1, three results in order, none lost, stall asserted.
- PIPELINED=0 → in_ready low from accept until capture; a second in_valid is held off, then accepted the following cycle.
- Assert reset while tok=010 → all outputs 0 next edge, no layer_en, in_ready=1; new sample completes normally.
- With FFNET_SEQ_PERF_EN and a 10-cycle stall → stall_cnt=10, result_cnt increments per capture.
